// File: rtl/seg_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl_if
// Purpose : Memory-mapped request/acknowledge bus used by seg_display_ctrl.
// Signals : iomem_valid  - request from the bus master
//           iomem_ready  - one-cycle acknowledge from the slave
//           iomem_wstrb  - byte write strobes, all zero for a read
//           iomem_addr   - byte address
//           iomem_wdata  - write data
//           iomem_rdata  - registered read data from the slave
// -----------------------------------------------------------------------------
interface seg_display_ctrl_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
// Purpose : Multiplexed 7-segment display controller with a bus-visible
//           register file (DATA, CTRL, STATUS), a seconds timebase and two
//           synchronised switch inputs.
// Ports   : clk            - single clock, all flops on its rising edge
//           resetn         - synchronous active-low reset
//           bus            - slave side of the iomem request/acknowledge bus
//           up_down_in     - asynchronous switch, visible in STATUS[1]
//           start_stop_in  - asynchronous switch, visible in STATUS[2]
//           comm           - digit commons, active-low, one digit at a time
//           seg            - segments, active-high, bit6=g .. bit0=a
//           colon          - colon drive, active-high
// Registers (iomem_addr[3:2]):
//           0 DATA   - one hex nibble per digit, byte-strobed
//           1 CTRL   - [0] EN, [1] BLINK, [2] COLON_AUTO, [3] COLON_VAL,
//                      [15:8] per-digit blank mask
//           2 STATUS - [0] sec_toggle, [1] up_down, [2] start_stop,
//                      [31:16] seconds counter; read-only
//           3 reserved, reads zero
// -----------------------------------------------------------------------------
module seg_display_ctrl #(
    parameter int          NUM_DIGITS  = 4,
    parameter int          REFRESH_DIV = 3840,
    parameter int          SEC_DIV     = 16000000,
    parameter logic [7:0]  BASE_ADDR   = 8'h05
) (
    input  logic                   clk,
    input  logic                   resetn,
    seg_display_ctrl_if.slave      bus,
    input  logic                   up_down_in,
    input  logic                   start_stop_in,
    output logic [NUM_DIGITS-1:0]  comm,
    output logic [6:0]             seg,
    output logic                   colon
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SEC_W  = $clog2(SEC_DIV);
    localparam int REF_W  = $clog2(REFRESH_DIV);
    localparam int DATA_W = 4 * NUM_DIGITS;

    // Shifting a 32-bit one by 32 yields zero, so the mask is all ones for 8 digits.
    localparam logic [31:0] DATA_MASK = (32'd1 << DATA_W) - 32'd1;
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF0F;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_CTRL   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;

    localparam logic [SEC_W-1:0] SEC_RELOAD = SEC_W'(SEC_DIV - 1);
    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    // Bus-side state
    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic [31:0]           r_data;
    logic [31:0]           r_ctrl;

    // Switch synchronisers
    logic                  r_ud_meta;
    logic                  r_ud_sync;
    logic                  r_ss_meta;
    logic                  r_ss_sync;

    // Timebase
    logic [SEC_W-1:0]      r_sec_cnt;
    logic                  r_sec_toggle;
    logic [15:0]           r_seconds;
    logic [REF_W-1:0]      r_ref_cnt;
    logic [IDX_W-1:0]      r_idx;

    // Registered display outputs
    logic [NUM_DIGITS-1:0] r_comm;
    logic [6:0]            r_seg;
    logic                  r_colon;

    // Combinational helpers
    logic                  w_sel;
    logic                  w_wr;
    logic [1:0]            w_reg;
    logic [31:0]           w_byte_mask;
    logic [31:0]           w_rd_data;
    logic [7:0]            w_blank_mask;
    logic                  w_blank;
    logic                  w_visible;
    logic [3:0]            w_nibble;
    logic                  w_unused_addr;

    // Only the base byte and the register field of the address are decoded.
    assign w_unused_addr = ^{bus.iomem_addr[23:4], bus.iomem_addr[1:0]};

    // A request already being acknowledged must not be taken a second time.
    assign w_sel = bus.iomem_valid && !r_ready && (bus.iomem_addr[31:24] == BASE_ADDR);
    assign w_wr  = w_sel && (bus.iomem_wstrb != 4'b0000);
    assign w_reg = bus.iomem_addr[3:2];

    assign w_byte_mask = {{8{bus.iomem_wstrb[3]}}, {8{bus.iomem_wstrb[2]}},
                          {8{bus.iomem_wstrb[1]}}, {8{bus.iomem_wstrb[0]}}};

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the case can leave it holding a value (no latch).
    always_comb begin
        w_rd_data = 32'h0;
        case (w_reg)
            REG_DATA:   w_rd_data = r_data;
            REG_CTRL:   w_rd_data = r_ctrl;
            REG_STATUS: w_rd_data = {r_seconds, 13'h0, r_ss_sync, r_ud_sync, r_sec_toggle};
            default:    w_rd_data = 32'h0;
        endcase
    end

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] pat;
        pat = 7'h00;
        case (nib)
            4'h0: pat = 7'h3F;
            4'h1: pat = 7'h06;
            4'h2: pat = 7'h5B;
            4'h3: pat = 7'h4F;
            4'h4: pat = 7'h66;
            4'h5: pat = 7'h6D;
            4'h6: pat = 7'h7D;
            4'h7: pat = 7'h07;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h6F;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h7C;
            4'hC: pat = 7'h39;
            4'hD: pat = 7'h5E;
            4'hE: pat = 7'h79;
            4'hF: pat = 7'h71;
            default: pat = 7'h00;
        endcase
        return pat;
    endfunction

    assign w_blank_mask = r_ctrl[15:8];
    assign w_blank      = w_blank_mask[r_idx];
    assign w_nibble     = r_data[{r_idx, 2'b00} +: 4];
    // BLINK hides every digit during the half-second where sec_toggle is low.
    assign w_visible    = r_ctrl[0] && !w_blank && !(r_ctrl[1] && !r_sec_toggle);

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_data  <= 32'h0;
            r_ctrl  <= 32'h0;
        end else begin
            r_ready <= w_sel;
            if (w_sel) begin
                r_rdata <= w_rd_data;
            end
            if (w_wr) begin
                case (w_reg)
                    REG_DATA: r_data <= ((r_data & ~w_byte_mask) |
                                         (bus.iomem_wdata & w_byte_mask)) & DATA_MASK;
                    REG_CTRL: r_ctrl <= ((r_ctrl & ~w_byte_mask) |
                                         (bus.iomem_wdata & w_byte_mask)) & CTRL_MASK;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ud_meta <= 1'b0;
            r_ud_sync <= 1'b0;
            r_ss_meta <= 1'b0;
            r_ss_sync <= 1'b0;
        end else begin
            r_ud_meta <= up_down_in;
            r_ud_sync <= r_ud_meta;
            r_ss_meta <= start_stop_in;
            r_ss_sync <= r_ss_meta;
        end
    end

    // Seconds timebase and digit scan; both counters count down and reload.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sec_cnt    <= SEC_RELOAD;
            r_sec_toggle <= 1'b1;
            r_seconds    <= 16'h0;
            r_ref_cnt    <= REF_RELOAD;
            r_idx        <= '0;
        end else begin
            if (r_sec_cnt == '0) begin
                r_sec_cnt    <= SEC_RELOAD;
                r_sec_toggle <= ~r_sec_toggle;
                r_seconds    <= r_seconds + 16'd1;
            end else begin
                r_sec_cnt <= r_sec_cnt - 1'b1;
            end

            if (r_ref_cnt == '0) begin
                r_ref_cnt <= REF_RELOAD;
                r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt - 1'b1;
            end
        end
    end

    // Display outputs are registered from current state, so a register write
    // or a tick shows up one cycle after the edge that caused it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_comm  <= '1;
            r_seg   <= 7'h00;
            r_colon <= 1'b0;
        end else begin
            if (w_visible) begin
                r_comm <= ~(NUM_DIGITS'(1) << r_idx);
                r_seg  <= hex_font(w_nibble);
            end else begin
                r_comm <= '1;
                r_seg  <= 7'h00;
            end
            r_colon <= r_ctrl[0] & (r_ctrl[2] ? r_sec_toggle : r_ctrl[3]);
        end
    end

    assign bus.iomem_ready = r_ready;
    assign bus.iomem_rdata = r_rdata;
    assign comm            = r_comm;
    assign seg             = r_seg;
    assign colon           = r_colon;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_display_ctrl
// Purpose : Self-checking bench for seg_display_ctrl. A driver issues bus
//           transactions and queues the expected read data; a monitor on the
//           falling edge pops and compares on every acknowledge, and compares
//           the display outputs against a cycle-count reference model.
// -----------------------------------------------------------------------------
module tb_seg_display_ctrl;

    localparam int         N    = 4;
    localparam int         REF  = 4;
    localparam int         SEC  = 8;
    localparam logic [7:0] BASE = 8'h05;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       up_down_in = 1'b0;
    logic       start_stop_in = 1'b0;
    logic [3:0] comm;
    logic [6:0] seg;
    logic       colon;

    seg_display_ctrl_if bus ();

    seg_display_ctrl #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (REF),
        .SEC_DIV     (SEC),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .bus           (bus),
        .up_down_in    (up_down_in),
        .start_stop_in (start_stop_in),
        .comm          (comm),
        .seg           (seg),
        .colon         (colon)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_it;
    int          total = 0;
    int          bad = 0;
    int          k = 0;            // edges since the last reset edge
    bit          rst_edge = 1'b0;  // the last edge sampled resetn low
    bit          disp_en = 1'b0;
    bit          hold_chk = 1'b0;
    logic        ready_prev = 1'b0;
    logic [31:0] rdata_prev = 32'h0;
    int          wait_cnt = 0;
    logic [31:0] m_data = 32'h0;
    logic [31:0] m_ctrl = 32'h0;

    always @(posedge clk) begin
        rst_edge <= !resetn;
        if (!resetn) k <= 0;
        else         k <= k + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] font(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    // Display seen after kk edges reflects the timebase after kk-1 edges.
    function automatic logic [31:0] disp_expect(input int kk);
        int         st;
        int         idx;
        bit         tog;
        bit         vis;
        logic [3:0] c;
        logic [6:0] s;
        logic       col;
        st  = kk - 1;
        idx = (st / REF) % N;
        tog = ((st / SEC) % 2) == 0;
        vis = m_ctrl[0] && !m_ctrl[8 + idx] && !(m_ctrl[1] && !tog);
        c   = vis ? ~(4'(1) << idx) : 4'hF;
        s   = vis ? font(m_data[4 * idx +: 4]) : 7'h00;
        col = m_ctrl[0] && (m_ctrl[2] ? tog : m_ctrl[3]);
        return {20'h0, col, s, c};
    endfunction

    // STATUS as sampled on the edge following kk completed edges.
    function automatic logic [31:0] status_expect(input int kk);
        int ticks;
        ticks = kk / SEC;
        return {16'(ticks % 65536), 13'h0, start_stop_in, up_down_in, 1'((ticks % 2) == 0)};
    endfunction

    // Monitor: scoreboard pop on acknowledge, display and hold checks.
    always @(negedge clk) begin
        if (rst_edge) begin
            check("reset_outputs", {19'h0, bus.iomem_ready, colon, seg, comm}, 32'h0000_000F);
            check("reset_rdata", bus.iomem_rdata, 32'h0);
            wait_cnt = 0;
        end else begin
            if (q.size() == 0) begin
                check("spurious_ready", {31'h0, bus.iomem_ready}, 32'h0);
            end else if (bus.iomem_ready) begin
                mon_it   = q.pop_front();
                wait_cnt = 0;
                check("ready_width", {31'h0, ready_prev}, 32'h0);
                if (mon_it.chk) check(mon_it.name, bus.iomem_rdata, mon_it.exp);
            end else begin
                wait_cnt++;
                if (wait_cnt > 20) begin
                    check("ready_timeout", {31'h0, bus.iomem_ready}, 32'h1);
                    void'(q.pop_front());
                    wait_cnt = 0;
                end
            end
            if (disp_en && k >= 1) check("display", {20'h0, colon, seg, comm}, disp_expect(k));
            if (hold_chk) check("rdata_hold", bus.iomem_rdata, rdata_prev);
        end
        ready_prev = bus.iomem_ready;
        rdata_prev = bus.iomem_rdata;
    end

    task automatic bus_op(input logic [7:0] top, input logic [1:0] r,
                          input logic [3:0] st, input logic [31:0] wd);
        exp_t        it;
        logic [31:0] m;
        @(negedge clk);
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {top, 20'h0, r, 2'b00};
        bus.iomem_wstrb = st;
        bus.iomem_wdata = wd;
        if (top == BASE) begin
            it.chk  = (st == 4'h0);
            it.name = $sformatf("read_reg%0d", r);
            case (r)
                2'd0:    it.exp = m_data;
                2'd1:    it.exp = m_ctrl;
                2'd2:    it.exp = status_expect(k);
                default: it.exp = 32'h0;
            endcase
            q.push_back(it);
            m = {{8{st[3]}}, {8{st[2]}}, {8{st[1]}}, {8{st[0]}}};
            if (r == 2'd0) m_data = ((m_data & ~m) | (wd & m)) & 32'h0000_FFFF;
            if (r == 2'd1) m_ctrl = ((m_ctrl & ~m) | (wd & m)) & 32'h0000_FF0F;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (bus.iomem_ready) break;
            end
        end else begin
            hold_chk = 1'b1;
            repeat (4) @(negedge clk);
            hold_chk = 1'b0;
        end
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
    endtask

    task automatic window(input int n);
        @(negedge clk);
        disp_en = 1'b1;
        repeat (n) @(negedge clk);
        disp_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.iomem_valid = 1'b0;
        bus.iomem_wstrb = 4'h0;
        bus.iomem_addr  = 32'h0;
        bus.iomem_wdata = 32'h0;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        window(8);

        // Scan pattern with all digits enabled
        bus_op(BASE, 2'd0, 4'hF, 32'h0000_1234);
        bus_op(BASE, 2'd1, 4'hF, 32'h0000_0001);
        bus_op(BASE, 2'd0, 4'h0, 32'h0);
        bus_op(BASE, 2'd1, 4'h0, 32'h0);
        window(24);

        // Byte-strobed blank of digit 2
        bus_op(BASE, 2'd1, 4'b0010, 32'h0000_0400);
        bus_op(BASE, 2'd1, 4'h0, 32'h0);
        window(16);

        // Blink with automatic colon, then fixed colon, then auto without blink
        bus_op(BASE, 2'd1, 4'hF, 32'h0000_0007);
        window(40);
        bus_op(BASE, 2'd2, 4'h0, 32'h0);
        bus_op(BASE, 2'd1, 4'hF, 32'h0000_0009);
        window(8);
        bus_op(BASE, 2'd1, 4'hF, 32'h0000_0005);
        window(12);

        // Unused bits, reserved register, read-only STATUS, foreign address
        bus_op(BASE, 2'd0, 4'hF, 32'hFFFF_FFFF);
        bus_op(BASE, 2'd0, 4'h0, 32'h0);
        bus_op(BASE, 2'd3, 4'hF, 32'hFFFF_FFFF);
        bus_op(BASE, 2'd3, 4'h0, 32'h0);
        bus_op(BASE, 2'd2, 4'hF, 32'hFFFF_FFFF);
        bus_op(BASE, 2'd2, 4'h0, 32'h0);
        bus_op(BASE + 8'd1, 2'd0, 4'h0, 32'h0);
        bus_op(BASE + 8'd1, 2'd0, 4'hF, 32'h0000_DEAD);
        bus_op(BASE, 2'd0, 4'h0, 32'h0);

        // Switch synchronisers
        up_down_in = 1'b1;
        repeat (3) @(negedge clk);
        bus_op(BASE, 2'd2, 4'h0, 32'h0);
        up_down_in    = 1'b0;
        start_stop_in = 1'b1;
        repeat (3) @(negedge clk);
        bus_op(BASE, 2'd2, 4'h0, 32'h0);

        // Randomised traffic
        for (int i = 0; i < 80; i++) begin
            logic [7:0]  top;
            logic [1:0]  r;
            logic [3:0]  st;
            logic [31:0] wd;
            if ($urandom_range(0, 7) == 0) begin
                up_down_in    = 1'($urandom_range(0, 1));
                start_stop_in = 1'($urandom_range(0, 1));
                repeat (3) @(negedge clk);
            end
            top = ($urandom_range(0, 9) == 0) ? BASE + 8'd1 : BASE;
            r   = 2'($urandom_range(0, 3));
            st  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            wd  = $urandom;
            bus_op(top, r, st, wd);
            if ($urandom_range(0, 3) == 0) window(6);
        end

        // Reset arriving together with a request
        bus_op(BASE, 2'd0, 4'hF, 32'h0000_BEEF);
        bus_op(BASE, 2'd1, 4'hF, 32'h0000_0001);
        @(negedge clk);
        resetn          = 1'b0;
        bus.iomem_valid = 1'b1;
        bus.iomem_addr  = {BASE, 24'h0};
        bus.iomem_wstrb = 4'h0;
        @(negedge clk);
        bus.iomem_valid = 1'b0;
        resetn          = 1'b1;
        m_data          = 32'h0;
        m_ctrl          = 32'h0;
        repeat (3) @(negedge clk);
        bus_op(BASE, 2'd0, 4'h0, 32'h0);
        bus_op(BASE, 2'd1, 4'h0, 32'h0);
        window(8);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 3840, clocks per digit slot, legal range >= 2.
REQ-003 SHALL have parameter SEC_DIV, default 16000000, clocks per second tick, legal range >= 2.
REQ-004 SHALL have parameter BASE_ADDR, default 8'h05, value matched against iomem_addr[31:24].
REQ-005 SHALL have port clk, input, 1, the single clock; every flop SHALL be clocked on posedge clk.
REQ-006 SHALL have port resetn, input, 1, reset that is synchronous and active-low.
REQ-007 SHALL have port iomem_valid, input, 1, bus request.
REQ-008 SHALL have port iomem_ready, output, 1, one-cycle acknowledge.
REQ-009 SHALL have port iomem_wstrb, input, 4, byte write strobes; 0 = read.
REQ-010 SHALL have port iomem_addr, input, 32, byte address.
REQ-011 SHALL have port iomem_wdata, input, 32, write data.
REQ-012 SHALL have port iomem_rdata, output, 32, registered read data.
REQ-013 SHALL have ports up_down_in and start_stop_in, input, 1 each, asynchronous switches.
REQ-014 SHALL have port comm, output, NUM_DIGITS, digit commons, active-low.
REQ-015 SHALL have port seg, output, 7, segments, active-high, bit6=g .. bit0=a.
REQ-016 SHALL have port colon, output, 1, colon drive, active-high.

Function
REQ-017 SHALL select a transaction when iomem_valid && !iomem_ready && iomem_addr[31:24]==BASE_ADDR; the register is iomem_addr[3:2].
REQ-018 SHALL, on each selected cycle, assert iomem_ready for exactly one cycle on the next edge and load iomem_rdata on that same edge; while ready is high, valid SHALL NOT start a second transaction.
REQ-019 SHALL leave iomem_ready low and iomem_rdata unchanged for non-matching addresses.
REQ-020 SHALL implement DATA (reg 0), read/write, byte-strobed, holding 4*NUM_DIGITS hex nibbles; digit i = DATA[4i+3:4i]; unimplemented bits SHALL read 0.
REQ-021 SHALL implement CTRL (reg 1), read/write, byte-strobed: bit0 EN, bit1 BLINK, bit2 COLON_AUTO, bit3 COLON_VAL, bits[15:8] BLANK mask (bit 8+i blanks digit i); other bits SHALL read 0.
REQ-022 SHALL implement STATUS (reg 2), read-only: bit0 sec_toggle, bit1 synced up_down, bit2 synced start_stop, bits[31:16] seconds counter; writes SHALL be acknowledged and ignored.
REQ-023 SHALL implement reg 3 as reserved: reads return 0, writes ignored, still acknowledged.
REQ-024 SHALL synchronise up_down_in and start_stop_in through two flops before use.
REQ-025 SHALL run a down-counter reloading to SEC_DIV-1; on reaching 0 it SHALL toggle sec_toggle and increment the 16-bit seconds counter, wrapping 0xFFFF -> 0x0000.
REQ-026 SHALL run a down-counter reloading to REFRESH_DIV-1; on reaching 0 digit index SHALL advance, NUM_DIGITS-1 wrapping to 0.
REQ-027 SHALL, for the active digit index d, drive comm with only bit d low when visible, else all ones.
REQ-028 SHALL treat digit d as visible when EN=1 and BLANK[d]=0 and not (BLINK=1 and sec_toggle=0).
REQ-029 SHALL drive seg with the standard hex font of digit d's nibble when visible, else 7'h00; font: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F,A=77,b=7C,C=39,d=5E,E=79,F=71.
REQ-030 SHALL drive colon = EN & (COLON_AUTO ? sec_toggle : COLON_VAL).
REQ-031 SHALL register comm, seg and colon (one-cycle latency from state change); no combinational path from bus to display outputs.
REQ-032 SHALL apply a DATA/CTRL write starting on the cycle after iomem_ready; a tick coincident with a write SHALL use the old value on that edge.

Reset
REQ-033 SHALL, when resetn=0 on a clock edge, clear DATA, CTRL, seconds counter, digit index and synchronisers; set sec_toggle=1; load both dividers to their reload values; drive iomem_ready=0, iomem_rdata=0, comm=all ones, seg=0, colon=0.
REQ-034 SHALL abandon any in-flight transaction on reset (no ready pulse after reset deasserts for a request seen before it).

Verification
VER-001 Write DATA=0x00001234, CTRL=0x1 (NUM_DIGITS=4, REFRESH_DIV=4) -> comm cycles 1110,1101,1011,0111 every 4 clocks; seg 66,4F,5B,06 respectively.
VER-002 Write CTRL with wstrb=4'b0010, wdata=0x00000400 after CTRL=0x1 -> CTRL reads 0x00000401; digit 2 slot shows comm=1111, seg=00.
VER-003 SEC_DIV=8, CTRL=0x7 -> colon and digit visibility toggle every 8 clocks; STATUS[31:16] increments each tick, wraps 0xFFFF->0x0000.
VER-004 Read reg 3, write STATUS, access BASE_ADDR+1 -> rdata 0 / no change / no ready pulse respectively; ready is always one cycle wide.
VER-005 Toggle up_down_in -> STATUS bit1 reflects it after 2-3 clocks.
VER-006 Assert resetn=0 mid-transaction with DATA nonzero -> next cycle comm=all ones, seg=00, iomem_ready=0; DATA reads 0 after release.
